hazard_interlock_unit: RTL
==========================

Name: hazard_interlock_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline; complements the EX-stage forwarding unit by covering the hazards bypassing cannot resolve.
- Detects load-use hazards, ID-stage branch operand hazards, and accesses to the multi-cycle multiply/divide (MD) unit while it is busy.
- Drives PC / IF-ID write enables, ID-EX bubble insertion and IF-ID flush.
- Holds a sequential MD busy down-counter and a saturating stall-cycle performance counter.

Parameters:
- N, 32, number of architectural registers; register index width is $clog2(N).
- MD_LATENCY, 4, cycles the MD unit is busy after a start (must be >=1).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- rs_id  in  $clog2(N)  rs field of the instruction in ID.
- rt_id  in  $clog2(N)  rt field of the instruction in ID.
- uses_rt_id  in  1  ID instruction reads rt as a source (R-type, store, beq/bne).
- branch_id  in  1  ID instruction is a conditional branch compared in ID.
- branch_taken_id  in  1  branch/jump in ID is resolved taken.
- hilo_read_id  in  1  ID instruction is mfhi/mflo.
- md_op_id  in  1  ID instruction is mult/multu/div/divu.
- write_reg_ex  in  $clog2(N)  destination register of the EX instruction.
- reg_write_ex  in  1  EX instruction writes the register file.
- mem_read_ex  in  1  EX instruction is a load.
- md_start_ex  in  1  MD operation enters EX this cycle.
- write_reg_mem  in  $clog2(N)  destination register of the MEM instruction.
- mem_read_mem  in  1  MEM instruction is a load.
- stat_clr  in  1  synchronous clear of stall_count.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register write enable.
- idex_bubble  out  1  zero the ID/EX control fields (insert NOP).
- ifid_flush  out  1  squash the IF/ID instruction.
- md_busy  out  1  MD unit still computing.
- md_err  out  1  sticky: md_start_ex seen while md_busy.
- stall_count  out  CNT_W  number of stall cycles since reset or clear.

Behaviour:
- Matching rule: a source matches a destination only if the destination is nonzero and indices are equal. rt is considered only when uses_rt_id=1.
- load_use = mem_read_ex and write_reg_ex matches rs_id or rt_id.
- br_haz = branch_id and either:
  - reg_write_ex and write_reg_ex matches rs_id or rt_id (EX result not ready for the ID compare), or
  - mem_read_mem and write_reg_mem matches rs_id or rt_id (load data not available until WB).
- md_haz = md_busy and (hilo_read_id or md_op_id).
- stall = load_use | br_haz | md_haz. All hazard and stall terms are combinational, same cycle.
- Output equations:
  - pc_write = ifid_write = !stall.
  - idex_bubble = stall.
  - ifid_flush = branch_taken_id & !stall. A taken branch that is stalled does not flush; the flush occurs in the cycle the stall releases.
- MD counter (md_cnt, width $clog2(MD_LATENCY+1)):
  - md_start_ex with md_busy=0: load MD_LATENCY on the next edge.
  - Otherwise, if md_cnt != 0: decrement by 1.
  - md_busy = (md_cnt != 0), registered-derived. The first busy cycle is the cycle after the start; busy lasts exactly MD_LATENCY cycles.
  - md_start_ex with md_busy=1: the counter is not reloaded, and md_err sets and stays set until reset.
- stall_count:
  - +1 on each edge where stall=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - stat_clr=1 forces 0 on that edge and has priority over increment.
- Reset (rst_n=0, immediate, no clock needed):
  - md_cnt=0, md_busy=0, md_err=0, stall_count=0.
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; the pipeline is frozen during reset.
  - After release, outputs follow the equations from the first cycle.
  - Reset during an MD operation aborts the countdown.
- Simultaneous hazards: causes are ORed. One stall cycle counts once regardless of how many causes are active.
- Register 0 never causes a hazard.

Test Plan:
1. Load-use: mem_read_ex=1, write_reg_ex=8, rs_id=8 -> pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle; stall_count 0->1. Repeat with write_reg_ex=0 -> no stall.
2. Branch after ALU op: branch_id=1, reg_write_ex=1, write_reg_ex=9, rt_id=9, uses_rt_id=1, branch_taken_id=1 -> stall and ifid_flush=0. Next cycle with EX cleared -> stall=0, ifid_flush=1.
3. Branch after load in MEM: mem_read_mem=1, write_reg_mem=5, rs_id=5, branch_id=1 -> stall 1 cycle. Same case with branch_id=0 -> no stall.
4. MD busy: pulse md_start_ex at cycle t -> md_busy=1 for cycles t+1..t+4 (MD_LATENCY=4). mflo in ID at t+2 -> stall through t+4, released at t+5. stall_count +3.
5. MD overlap and reset: md_start_ex at t and t+1 -> md_err=1, md_busy still ends at t+4. Assert rst_n=0 mid-count -> md_busy=0, md_err=0, idex_bubble=1 immediately, without a clock edge.
6. Counter: CNT_W=4, hold stall 20 cycles -> stall_count saturates at 15. stat_clr together with stall -> 0.

Source files
------------

// File: rtl/hazard_interlock_unit_if.sv
// Hazard interlock bus: pipeline-stage hazard inputs and stall/flush outputs.
// master: pipeline side (drives the stage fields, receives the controls).
// slave:  hazard_interlock_unit (reads the stage fields, drives the controls).
// Parameters N (register count) and CNT_W (stall counter width) must match the
// values given to the hazard_interlock_unit instance bound to this interface.
interface hazard_interlock_unit_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] rs_id;
  logic [IDX_W-1:0] rt_id;
  logic             uses_rt_id;
  logic             branch_id;
  logic             branch_taken_id;
  logic             hilo_read_id;
  logic             md_op_id;
  logic [IDX_W-1:0] write_reg_ex;
  logic             reg_write_ex;
  logic             mem_read_ex;
  logic             md_start_ex;
  logic [IDX_W-1:0] write_reg_mem;
  logic             mem_read_mem;
  logic             stat_clr;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             md_busy;
  logic             md_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output rs_id, rt_id, uses_rt_id, branch_id, branch_taken_id, hilo_read_id,
           md_op_id, write_reg_ex, reg_write_ex, mem_read_ex, md_start_ex,
           write_reg_mem, mem_read_mem, stat_clr,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, md_busy, md_err,
           stall_count
  );

  modport slave (
    input  rs_id, rt_id, uses_rt_id, branch_id, branch_taken_id, hilo_read_id,
           md_op_id, write_reg_ex, reg_write_ex, mem_read_ex, md_start_ex,
           write_reg_mem, mem_read_mem, stat_clr,
    output pc_write, ifid_write, idex_bubble, ifid_flush, md_busy, md_err,
           stall_count
  );
endinterface

// File: rtl/hazard_interlock_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline. Covers hazards that
// EX-stage forwarding cannot resolve: load-use, ID-stage branch operands, and
// mfhi/mflo or MD ops issued while the multiply/divide unit is still busy.
// Ports:
//   clk   - pipeline clock, rising edge
//   rst_n - asynchronous reset, active low; freezes the pipeline while low
//   hif   - slave side of hazard_interlock_unit_if: stage fields in,
//           pc_write/ifid_write/idex_bubble/ifid_flush, md_busy, md_err
//           and stall_count out
module hazard_interlock_unit #(
  parameter int unsigned N          = 32,
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hazard_interlock_unit_if.slave  hif
);
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned MD_W  = $clog2(MD_LATENCY + 1);

  logic [MD_W-1:0]  mdCnt;
  logic             mdBusy;
  logic             mdErr;
  logic [CNT_W-1:0] stallCnt;

  logic rsHitEx, rtHitEx, rsHitMem, rtHitMem;
  logic loadUse, brHaz, mdHaz, stall;

  // Register 0 is hardwired to zero, so it never carries a dependency.
  function automatic logic regMatch(input logic [IDX_W-1:0] dst,
                                    input logic [IDX_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  always_comb begin
    rsHitEx  = regMatch(hif.write_reg_ex, hif.rs_id);
    rtHitEx  = hif.uses_rt_id && regMatch(hif.write_reg_ex, hif.rt_id);
    rsHitMem = regMatch(hif.write_reg_mem, hif.rs_id);
    rtHitMem = hif.uses_rt_id && regMatch(hif.write_reg_mem, hif.rt_id);

    loadUse  = hif.mem_read_ex && (rsHitEx || rtHitEx);
    // Branches compare in ID, so even an ALU result in EX is too late, and a
    // load in MEM only delivers its data in WB.
    brHaz    = hif.branch_id &&
               ((hif.reg_write_ex && (rsHitEx || rtHitEx)) ||
                (hif.mem_read_mem && (rsHitMem || rtHitMem)));
    mdHaz    = mdBusy && (hif.hilo_read_id || hif.md_op_id);
    stall    = loadUse || brHaz || mdHaz;
  end

  assign mdBusy = (mdCnt != '0);

  // rst_n gates the controls directly so the pipeline freezes the instant
  // reset asserts, without waiting for a clock edge.
  assign hif.pc_write    = rst_n && !stall;
  assign hif.ifid_write  = rst_n && !stall;
  assign hif.idex_bubble = !rst_n || stall;
  assign hif.ifid_flush  = rst_n && hif.branch_taken_id && !stall;
  assign hif.md_busy     = mdBusy;
  assign hif.md_err      = mdErr;
  assign hif.stall_count = stallCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdCnt <= '0;
      mdErr <= 1'b0;
    end else begin
      if (hif.md_start_ex && !mdBusy) begin
        mdCnt <= MD_W'(MD_LATENCY);
      end else if (mdBusy) begin
        mdCnt <= mdCnt - 1'b1;
      end
      if (hif.md_start_ex && mdBusy) begin
        mdErr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (hif.stat_clr) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end
endmodule
